regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
- Access controller between the barrel pipeline's decode/writeback stages and the two simple-dual-port register-file RAMs (one per source operand, identical contents).
- After reset, clears every thread's register file by sweeping the RAM write port.
- In run mode, issues rs1/rs2 reads, returns operands aligned to the RAM's 1-cycle read latency, and drives writeback into both RAMs.
- Forces x0 to zero and bypasses same-cycle read/write address collisions, which the RAM does not resolve.

Parameters:
- THREAD_BITS, 4, log2 of hardware thread count (16 threads).
- REG_BITS, 5, architectural register index width.
- XLEN, 32, register data width.
- ADDR_WIDTH, THREAD_BITS+REG_BITS (9), RAM address = {tid, reg}.
- SIZE, 2**ADDR_WIDTH (512), RAM depth and number of clear-sweep entries.

Ports:
- clk  in  1  single clock for block and RAMs
- reset  in  1  synchronous, active-high
- rd_valid  in  1  decode presents a read request
- rd_ready  out  1  request accepted this cycle
- rd_tid  in  THREAD_BITS  thread of request
- rd_rs1  in  REG_BITS  source register 1
- rd_rs2  in  REG_BITS  source register 2
- op_valid  out  1  operands valid (1 cycle after accept)
- op_tid  out  THREAD_BITS  thread of returned operands
- op_rs1_data  out  XLEN  rs1 value
- op_rs2_data  out  XLEN  rs2 value
- wb_valid  in  1  writeback request
- wb_tid  in  THREAD_BITS  writeback thread
- wb_rd  in  REG_BITS  destination register
- wb_data  in  XLEN  writeback value
- wb_drop  out  1  pulse: wb_valid seen while clearing, discarded
- init_busy  out  1  clear sweep in progress
- ram_ena  out  1  write-port enable to both RAMs
- ram_wea  out  1  write enable to both RAMs
- ram_addra  out  ADDR_WIDTH  write address
- ram_dia  out  XLEN  write data
- ram_enb  out  1  read enable to both RAMs
- ram_addrb1  out  ADDR_WIDTH  read address, RAM 1
- ram_addrb2  out  ADDR_WIDTH  read address, RAM 2
- ram_dob1  in  XLEN  RAM 1 read data (registered in RAM)
- ram_dob2  in  XLEN  RAM 2 read data

Behaviour:
- States: INIT and RUN.
- Reset: state=INIT, sweep counter=0; op_valid=0, wb_drop=0, init_busy=1, rd_ready=0. op_tid and op data reset to 0.
- INIT, each cycle:
  - ram_ena=ram_wea=1, ram_addra=counter, ram_dia=0; counter+1.
  - When counter==SIZE-1 is written, go to RUN next cycle. The sweep takes exactly SIZE cycles.
  - rd_ready=0, ram_enb=0.
  - wb_valid → wb_drop=1 next cycle, and no write occurs.
- RUN:
  - init_busy=0 and rd_ready=1 continuously. There is no operand backpressure: the barrel pipeline never stalls.
  - On accept at cycle t: ram_enb=1, ram_addrb1={rd_tid,rd_rs1}, ram_addrb2={rd_tid,rd_rs2}, all combinational. In cycle t+1: op_valid=1, op_tid=rd_tid registered.
  - Writeback is combinational: ram_ena=ram_wea=wb_valid && wb_rd!=0, ram_addra={wb_tid,wb_rd}, ram_dia=wb_data.
  - Writes to x0 are suppressed, so the RAMs are never written at reg 0 after the sweep.
  - When ram_enb=0, ram_addrb* hold 0.
- Operand select in cycle t+1, per operand, evaluated at accept cycle t and registered:
  - rs==0 → 0.
  - Else, if a RUN write occurs at t to the same {tid,rs} → the wb_data of cycle t (collision bypass).
  - Else → ram_dob.
  - Write at t-1, read at t: no bypass; the RAM already holds the value.
- Both operands may hit the bypass in the same cycle (rs1==rs2==rd).
- Reset mid-RUN: op_valid drops to 0 on the next edge and the sweep restarts at 0. In-flight reads are discarded.
- Reset during INIT restarts the counter at 0.
- Counter width is ADDR_WIDTH; it stops at SIZE-1 and does not wrap into RUN.

Decomposition:
- The shared package (riscv_pkg) holds:
  - THREAD_BITS, REG_BITS, XLEN;
  - the rf_addr_t typedef (ADDR_WIDTH bits);
  - the rf_state_t enum {INIT, RUN};
  - the helper function packing {tid,reg} into rf_addr_t.
- Sub-module rf_bypass_sel: one operand's registered select (zero / bypass / RAM), instantiated twice.
- The RAMs are instantiated by the parent, not inside this block.

Test Plan:
- Reset, then 512 cycles idle → init_busy=1 for exactly 512 cycles; ram_addra sweeps 0..511 with ram_dia=0. Cycle 513: rd_ready=1.
- wb_valid during INIT (tid 3, rd 5, 0xDEAD) → wb_drop pulse, ram_wea=0 for that cycle. A later read of t3/x5 returns 0.
- RUN: write t2/x7=0x12345678; next cycle read t2 rs1=7 rs2=0 → cycle after: op_rs1_data=0x12345678, op_rs2_data=0, op_tid=2.
- Same-cycle write t9/x31=0xCAFEF00D with read t9 rs1=31 rs2=31 → both operands 0xCAFEF00D. Write t8/x31 with read t9/x31 → no bypass; the RAM value is returned.
- Write t1/x0=0xFFFFFFFF → ram_wea stays 0. Reading t1 rs1=0 returns 0.
- Assert reset mid-stream with op_valid=1 → op_valid=0 next cycle, init_busy=1, and the sweep restarts at address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file definitions for the barrel pipeline: geometry,
// RAM address type, controller states and operand-select encoding.
package riscv_pkg;

    localparam int THREAD_BITS = 4;
    localparam int REG_BITS    = 5;
    localparam int XLEN        = 32;
    localparam int ADDR_WIDTH  = THREAD_BITS + REG_BITS;
    localparam int SIZE        = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] rf_addr_t;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    // Where an operand comes from in the cycle after the read is accepted
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_BYPASS,
        SEL_RAM
    } rf_sel_t;

    // RAM address is the thread id on top of the architectural register index
    function automatic rf_addr_t rf_pack(input logic [THREAD_BITS-1:0] tid,
                                         input logic [REG_BITS-1:0]    regIdx);
        return {tid, regIdx};
    endfunction

endpackage

// File: rtl/rf_bypass_sel.sv
// One operand's source select. The choice between zero, a same-cycle
// writeback value and the RAM output is made when the read is accepted and
// registered, so it lines up with the RAM's one-cycle read latency.
module rf_bypass_sel
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_accept,
    input  rf_addr_t        i_rdAddr,
    input  logic            i_wrEn,
    input  rf_addr_t        i_wrAddr,
    input  logic [XLEN-1:0] i_wrData,
    input  logic [XLEN-1:0] i_ramDout,
    output logic [XLEN-1:0] o_data
);

    rf_sel_t         w_selNext;
    rf_sel_t         r_sel;
    logic [XLEN-1:0] r_bypData;

    // Pick the operand source for a read accepted this cycle; x0 always wins,
    // then a colliding write (the RAM would return the stale value), else RAM
    always_comb begin
        w_selNext = SEL_ZERO;
        if (i_accept) begin
            if (i_rdAddr[REG_BITS-1:0] == '0) begin
                w_selNext = SEL_ZERO;
            end else if (i_wrEn && (i_wrAddr == i_rdAddr)) begin
                w_selNext = SEL_BYPASS;
            end else begin
                w_selNext = SEL_RAM;
            end
        end
    end

    // Hold the select and the captured writeback data for the return cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= SEL_ZERO;
            r_bypData <= '0;
        end else begin
            r_sel     <= w_selNext;
            r_bypData <= i_wrData;
        end
    end

    // Steer the selected source onto the operand bus
    always_comb begin
        o_data = '0;
        unique case (r_sel)
            SEL_BYPASS: o_data = r_bypData;
            SEL_RAM:    o_data = i_ramDout;
            default:    o_data = '0;
        endcase
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file access controller: clears every thread's registers after
// reset, then serves rs1/rs2 reads and writebacks against two mirrored
// simple-dual-port RAMs, forcing x0 to zero and bypassing write/read
// collisions that the RAMs do not resolve.
module regfile_port_ctrl
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [THREAD_BITS-1:0] rd_tid,
    input  logic [REG_BITS-1:0]    rd_rs1,
    input  logic [REG_BITS-1:0]    rd_rs2,
    output logic                   op_valid,
    output logic [THREAD_BITS-1:0] op_tid,
    output logic [XLEN-1:0]        op_rs1_data,
    output logic [XLEN-1:0]        op_rs2_data,
    input  logic                   wb_valid,
    input  logic [THREAD_BITS-1:0] wb_tid,
    input  logic [REG_BITS-1:0]    wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   wb_drop,
    output logic                   init_busy,
    output logic                   ram_ena,
    output logic                   ram_wea,
    output logic [ADDR_WIDTH-1:0]  ram_addra,
    output logic [XLEN-1:0]        ram_dia,
    output logic                   ram_enb,
    output logic [ADDR_WIDTH-1:0]  ram_addrb1,
    output logic [ADDR_WIDTH-1:0]  ram_addrb2,
    input  logic [XLEN-1:0]        ram_dob1,
    input  logic [XLEN-1:0]        ram_dob2
);

    localparam rf_addr_t LAST_ADDR = rf_addr_t'(SIZE - 1);

    rf_state_t              r_state;
    rf_state_t              w_stateNext;
    rf_addr_t               r_count;
    logic                   r_opValid;
    logic [THREAD_BITS-1:0] r_opTid;
    logic                   r_wbDrop;

    logic                   w_accept;
    logic                   w_wrEn;
    rf_addr_t               w_wrAddr;
    rf_addr_t               w_rdAddr1;
    rf_addr_t               w_rdAddr2;

    assign w_accept  = (r_state == RUN) && rd_valid;
    assign w_wrEn    = (r_state == RUN) && wb_valid && (wb_rd != '0);
    assign w_wrAddr  = rf_pack(wb_tid, wb_rd);
    assign w_rdAddr1 = rf_pack(rd_tid, rd_rs1);
    assign w_rdAddr2 = rf_pack(rd_tid, rd_rs2);

    // State register and clear-sweep counter; the counter parks on the last
    // address instead of wrapping so RUN never sees a stray sweep value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == INIT) && (r_count != LAST_ADDR)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Next state plus all RAM port and handshake outputs
    always_comb begin
        w_stateNext = r_state;
        rd_ready    = 1'b0;
        init_busy   = 1'b0;
        ram_ena     = 1'b0;
        ram_wea     = 1'b0;
        ram_addra   = '0;
        ram_dia     = '0;
        ram_enb     = 1'b0;
        ram_addrb1  = '0;
        ram_addrb2  = '0;
        unique case (r_state)
            INIT: begin
                init_busy = 1'b1;
                ram_ena   = 1'b1;
                ram_wea   = 1'b1;
                ram_addra = r_count;
                ram_dia   = '0;
                if (r_count == LAST_ADDR) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                rd_ready  = 1'b1;
                ram_ena   = w_wrEn;
                ram_wea   = w_wrEn;
                ram_addra = w_wrAddr;
                ram_dia   = wb_data;
                ram_enb   = w_accept;
                if (w_accept) begin
                    ram_addrb1 = w_rdAddr1;
                    ram_addrb2 = w_rdAddr2;
                end
            end
            default: begin
                w_stateNext = INIT;
            end
        endcase
    end

    // Operand-valid timing, returned thread id and the dropped-writeback pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opValid <= 1'b0;
            r_opTid   <= '0;
            r_wbDrop  <= 1'b0;
        end else begin
            r_opValid <= w_accept;
            if (w_accept) begin
                r_opTid <= rd_tid;
            end
            r_wbDrop <= (r_state == INIT) && wb_valid;
        end
    end

    assign op_valid = r_opValid;
    assign op_tid   = r_opTid;
    assign wb_drop  = r_wbDrop;

    rf_bypass_sel u_sel1 (
        .clk       (clk),
        .reset     (reset),
        .i_accept  (w_accept),
        .i_rdAddr  (w_rdAddr1),
        .i_wrEn    (w_wrEn),
        .i_wrAddr  (w_wrAddr),
        .i_wrData  (wb_data),
        .i_ramDout (ram_dob1),
        .o_data    (op_rs1_data)
    );

    rf_bypass_sel u_sel2 (
        .clk       (clk),
        .reset     (reset),
        .i_accept  (w_accept),
        .i_rdAddr  (w_rdAddr2),
        .i_wrEn    (w_wrEn),
        .i_wrAddr  (w_wrAddr),
        .i_wrData  (wb_data),
        .i_ramDout (ram_dob2),
        .o_data    (op_rs2_data)
    );

endmodule
